// File: rtl/sha_mem_responder.sv
// Shared message/digest RAM between a host load stream, a SHA core acting as
// memory master, and a digest output stream; sequences one hash job at a time.
module sha_mem_responder #(
  parameter int unsigned MSG_WORDS = 20,
  parameter logic [15:0] MSG_BASE  = 16'h0000,
  parameter logic [15:0] OUT_BASE  = 16'h0080,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_valid,
  input  logic [31:0] host_data,
  output logic        host_ready,
  output logic        dig_valid,
  output logic [31:0] dig_data,
  input  logic        dig_ready,
  output logic        core_start,
  input  logic        core_done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic [15:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        addr_err,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MSG_BASE8 = MSG_BASE[7:0];
  localparam logic [7:0] OUT_BASE8 = OUT_BASE[7:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [2:0]    dig_idx_q, dig_idx_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          done_prev_q, done_prev_d;
  logic          dig_valid_q, dig_valid_d;
  logic [31:0]   dig_data_q, dig_data_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          addr_err_q, addr_err_d;
  logic          timeout_err_q, timeout_err_d;

  logic [31:0]   ram [256];
  logic          core_in_range;
  logic          core_wr_en;
  logic          host_wr_en;
  logic [7:0]    host_wr_addr;
  logic [7:0]    dig_rd_addr;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    dig_idx_d     = dig_idx_q;
    tmo_cnt_d     = tmo_cnt_q;
    dig_valid_d   = dig_valid_q;
    dig_data_d    = dig_data_q;
    timeout_err_d = timeout_err_q;
    done_prev_d   = core_done;
    host_ready    = 1'b0;
    core_start    = 1'b0;
    host_wr_en    = 1'b0;
    host_wr_addr  = MSG_BASE8 + idx_q;
    // With a word already presented, fetch the one after it so an accepting
    // handshake can be followed immediately by the next word.
    dig_rd_addr   = OUT_BASE8 + {5'd0, dig_idx_q} + {7'd0, dig_valid_q};

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (host_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        host_ready = 1'b1;
        if (host_valid) begin
          host_wr_en = 1'b1;
          idx_d      = idx_q + 8'd1;
          if (idx_q == 8'(MSG_WORDS - 1)) state_d = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        tmo_cnt_d  = '0;
        state_d    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (core_done && !done_prev_q) begin
          dig_idx_d = '0;
          state_d   = S_DRAIN;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (!dig_valid_q) begin
          dig_data_d  = ram[dig_rd_addr];
          dig_valid_d = 1'b1;
        end else if (dig_ready) begin
          dig_idx_d = dig_idx_q + 3'd1;
          if (dig_idx_q == 3'd7) begin
            dig_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            dig_data_d = ram[dig_rd_addr];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Core port: every cycle is a read; out-of-range addresses read as zero.
  always_comb begin
    core_in_range = (mem_addr[15:8] == 8'h00);
    core_wr_en    = mem_we && core_in_range &&
                    ((state_q == S_START) || (state_q == S_WAIT_DONE));
    rd_data_d     = core_in_range ? ram[mem_addr[7:0]] : '0;
    addr_err_d    = addr_err_q | ~core_in_range;
  end

  always_ff @(posedge clk) begin
    if (host_wr_en) begin
      ram[host_wr_addr] <= host_data;
    end else if (core_wr_en) begin
      ram[mem_addr[7:0]] <= mem_write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      dig_idx_q     <= '0;
      tmo_cnt_q     <= '0;
      done_prev_q   <= 1'b0;
      dig_valid_q   <= 1'b0;
      dig_data_q    <= '0;
      rd_data_q     <= '0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dig_idx_q     <= dig_idx_d;
      tmo_cnt_q     <= tmo_cnt_d;
      done_prev_q   <= done_prev_d;
      dig_valid_q   <= dig_valid_d;
      dig_data_q    <= dig_data_d;
      rd_data_q     <= rd_data_d;
      addr_err_q    <= addr_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    message_addr  = MSG_BASE;
    output_addr   = OUT_BASE;
    dig_valid     = dig_valid_q;
    dig_data      = dig_data_q;
    mem_read_data = rd_data_q;
    busy          = (state_q != S_IDLE);
    addr_err      = addr_err_q;
    timeout_err   = timeout_err_q;
  end

endmodule
